// File: rtl/ycc2rgb_pkg.sv
// ycc2rgb_pkg: shared definitions for the YCbCr->RGB sequencer slice.
//   ROW_R/ROW_G/ROW_B : row tags carried with each pass through the stage chain
//   state_t           : sequencer FSM states
//   FRAC_BITS         : fractional bits in the chain accumulator
package ycc2rgb_pkg;

  localparam int unsigned FRAC_BITS = 8;

  localparam logic [1:0] ROW_R = 2'd0;
  localparam logic [1:0] ROW_G = 2'd1;
  localparam logic [1:0] ROW_B = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/ycc2rgb_sat_round.sv
// ycc2rgb_sat_round: combinational conversion of a signed fixed-point
// accumulator (FRAC_BITS fractional bits) to an unsigned 8-bit component.
//   acc : signed accumulator, ACC_W bits (ACC_W >= 17)
//   val : clamped 8-bit result, negative -> 0, above 255 -> 255
// Build option: define YCC2RGB_ROUND_EN to round half up before the shift;
// otherwise the fraction is truncated toward minus infinity.
module ycc2rgb_sat_round
  import ycc2rgb_pkg::*;
#(
  parameter int unsigned ACC_W = 17
) (
  input  logic [ACC_W-1:0] acc,
  output logic [7:0]       val
);

  localparam int unsigned VW = ACC_W + 1 - FRAC_BITS;

  logic [ACC_W:0]           sum;
  logic [VW-1:0]            v;
  logic [FRAC_BITS-1:0]     unused_frac;

`ifdef YCC2RGB_ROUND_EN
  localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(2 ** (FRAC_BITS - 1));
  // One guard bit so adding the half LSB can never overflow.
  assign sum = {acc[ACC_W-1], acc} + HALF;
`else
  assign sum = {acc[ACC_W-1], acc};
`endif

  // Taking the upper bits of the sign-extended sum is the arithmetic shift.
  assign v           = sum[ACC_W:FRAC_BITS];
  assign unused_frac = sum[FRAC_BITS-1:0];

  always_comb begin
    if (v[VW-1])
      val = '0;
    else if (|v[VW-2:8])
      val = '1;
    else
      val = v[7:0];
  end

endmodule

// File: rtl/ycbcr_to_rgb_seq_ctrl.sv
// ycbcr_to_rgb_seq_ctrl: sequencer for the YCbCr->RGB multiply-accumulate
// stage chain. Latches one pixel, issues R/G/B passes on three consecutive
// cycles, collects the tagged accumulator results, and presents the rounded,
// clamped RGB pixel with valid/ready handshaking.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   pix_valid_i/pix_ready_o          input pixel handshake
//   y_i, cb_i, cr_i                  input components
//   stg_valid_o, stg_state_o         issue strobe and row tag to the chain
//   stg_y_o, stg_cb_o, stg_cr_o      latched components for the chain
//   res_valid_i, res_state_i         result strobe and row tag from the chain
//   res_data_i                       signed accumulator (8 fractional bits)
//   rgb_valid_o/rgb_ready_i          output pixel handshake
//   r_o, g_o, b_o                    output components
//   err_o                            sticky error: timeout, tag 3, duplicate tag
// Build option: YCC2RGB_ROUND_EN selects round-half-up (see ycc2rgb_sat_round).
module ycbcr_to_rgb_seq_ctrl
  import ycc2rgb_pkg::*;
#(
  parameter int unsigned ACC_W   = 17,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid_i,
  output logic             pix_ready_o,
  input  logic [7:0]       y_i,
  input  logic [7:0]       cb_i,
  input  logic [7:0]       cr_i,
  output logic             stg_valid_o,
  output logic [1:0]       stg_state_o,
  output logic [7:0]       stg_y_o,
  output logic [7:0]       stg_cb_o,
  output logic [7:0]       stg_cr_o,
  input  logic             res_valid_i,
  input  logic [1:0]       res_state_i,
  input  logic [ACC_W-1:0] res_data_i,
  output logic             rgb_valid_o,
  input  logic             rgb_ready_i,
  output logic [7:0]       r_o,
  output logic [7:0]       g_o,
  output logic [7:0]       b_o,
  output logic             err_o
);

  localparam int unsigned   TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic             live;
  logic [1:0]       issue_cnt;
  logic [TW-1:0]    tcnt;
  logic [2:0]       mask;
  logic [ACC_W-1:0] acc_q [3];
  logic [7:0]       y_q, cb_q, cr_q;
  logic             err_q;

  logic             accept;
  logic             collect;
  logic             tag_bad;
  logic [2:0]       hit;
  logic             dup;
  logic             timeout;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pix_ready_o = 1'b0;
    stg_valid_o = 1'b0;
    stg_state_o = '0;
    rgb_valid_o = 1'b0;
    case (state)
      IDLE: begin
        pix_ready_o = live;
        if (pix_valid_i && live)
          state_nxt = ISSUE;
      end
      ISSUE: begin
        stg_valid_o = 1'b1;
        stg_state_o = issue_cnt;
        if (issue_cnt == ROW_B)
          state_nxt = WAIT;
      end
      WAIT: begin
        if (mask == 3'b111 || timeout)
          state_nxt = OUT;
      end
      OUT: begin
        rgb_valid_o = 1'b1;
        if (rgb_ready_i)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------- result decoding
  assign accept  = pix_valid_i & pix_ready_o;
  assign collect = res_valid_i & ((state == ISSUE) | (state == WAIT));
  assign tag_bad = collect & (res_state_i == 2'd3);
  assign hit     = (collect && !tag_bad) ? 3'(3'b001 << res_state_i) : 3'b000;
  assign dup     = |(hit & mask);
  assign timeout = (state == WAIT) && (mask != 3'b111) && (tcnt == T_LAST);

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live      <= 1'b0;
      issue_cnt <= '0;
      tcnt      <= '0;
      mask      <= '0;
      y_q       <= '0;
      cb_q      <= '0;
      cr_q      <= '0;
      err_q     <= 1'b0;
      for (int unsigned i = 0; i < 3; i++)
        acc_q[i] <= '0;
    end else begin
      // Holds pix_ready_o low for the first cycle out of reset.
      live <= 1'b1;

      if (state == ISSUE && state_nxt == ISSUE)
        issue_cnt <= issue_cnt + 2'd1;
      else
        issue_cnt <= '0;

      if (state == WAIT)
        tcnt <= tcnt + 1'b1;
      else
        tcnt <= '0;

      if (accept) begin
        y_q  <= y_i;
        cb_q <= cb_i;
        cr_q <= cr_i;
        mask <= '0;
      end else begin
        mask <= mask | hit;
      end

      // A result landing on the timeout cycle still wins over the forced zero.
      for (int unsigned i = 0; i < 3; i++) begin
        if (hit[i])
          acc_q[i] <= res_data_i;
        else if (timeout && !mask[i])
          acc_q[i] <= '0;
      end

      if (tag_bad || dup || timeout)
        err_q <= 1'b1;
    end
  end

  assign stg_y_o  = y_q;
  assign stg_cb_o = cb_q;
  assign stg_cr_o = cr_q;
  assign err_o    = err_q;

  // ---------------------------------------------------- output channels
  ycc2rgb_sat_round #(.ACC_W(ACC_W)) u_sat_r (.acc(acc_q[ROW_R]), .val(r_o));
  ycc2rgb_sat_round #(.ACC_W(ACC_W)) u_sat_g (.acc(acc_q[ROW_G]), .val(g_o));
  ycc2rgb_sat_round #(.ACC_W(ACC_W)) u_sat_b (.acc(acc_q[ROW_B]), .val(b_o));

endmodule

// File: tb/tb_ycbcr_to_rgb_seq_ctrl.sv
// tb_ycbcr_to_rgb_seq_ctrl: directed bench for ycbcr_to_rgb_seq_ctrl with
// ACC_W=18, TIMEOUT=32. Results are driven by hand in place of the stage chain.
module tb_ycbcr_to_rgb_seq_ctrl;

  localparam int unsigned ACC_W   = 18;
  localparam int unsigned TIMEOUT = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             pix_valid_i = 1'b0;
  logic             pix_ready_o;
  logic [7:0]       y_i = '0, cb_i = '0, cr_i = '0;
  logic             stg_valid_o;
  logic [1:0]       stg_state_o;
  logic [7:0]       stg_y_o, stg_cb_o, stg_cr_o;
  logic             res_valid_i = 1'b0;
  logic [1:0]       res_state_i = '0;
  logic [ACC_W-1:0] res_data_i = '0;
  logic             rgb_valid_o;
  logic             rgb_ready_i = 1'b1;
  logic [7:0]       r_o, g_o, b_o;
  logic             err_o;

  int unsigned total  = 0;
  int unsigned passed = 0;

  logic [1:0]       rt [4];
  logic [ACC_W-1:0] rd [4];

  ycbcr_to_rgb_seq_ctrl #(.ACC_W(ACC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
    .y_i(y_i), .cb_i(cb_i), .cr_i(cr_i),
    .stg_valid_o(stg_valid_o), .stg_state_o(stg_state_o),
    .stg_y_o(stg_y_o), .stg_cb_o(stg_cb_o), .stg_cr_o(stg_cr_o),
    .res_valid_i(res_valid_i), .res_state_i(res_state_i), .res_data_i(res_data_i),
    .rgb_valid_o(rgb_valid_o), .rgb_ready_i(rgb_ready_i),
    .r_o(r_o), .g_o(g_o), .b_o(b_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".pix_ready"}, 32'(pix_ready_o), 0);
    check({tag, ".stg_valid"}, 32'(stg_valid_o), 0);
    check({tag, ".stg_state"}, 32'(stg_state_o), 0);
    check({tag, ".stg_y"},     32'(stg_y_o),     0);
    check({tag, ".stg_cb"},    32'(stg_cb_o),    0);
    check({tag, ".stg_cr"},    32'(stg_cr_o),    0);
    check({tag, ".rgb_valid"}, 32'(rgb_valid_o), 0);
    check({tag, ".r"},         32'(r_o),         0);
    check({tag, ".g"},         32'(g_o),         0);
    check({tag, ".b"},         32'(b_o),         0);
    check({tag, ".err"},       32'(err_o),       0);
  endtask

  task automatic check_rgb(input string tag, input int r, input int g, input int b, input int e);
    check({tag, ".valid"}, 32'(rgb_valid_o), 1);
    check({tag, ".r"},     32'(r_o), 32'(r));
    check({tag, ".g"},     32'(g_o), 32'(g));
    check({tag, ".b"},     32'(b_o), 32'(b));
    check({tag, ".err"},   32'(err_o), 32'(e));
  endtask

  // Called at a negedge. Offers one pixel, checks the three issue cycles,
  // returns n results (rt/rd) starting on the third issue cycle, then waits
  // for rgb_valid_o and checks how many cycles that took.
  task automatic run_pixel(input string tag, input logic [7:0] y, input logic [7:0] cb,
                           input logic [7:0] cr, input int n, input int exp_wait);
    int k;
    y_i = y; cb_i = cb; cr_i = cr;
    pix_valid_i = 1'b1;
    k = 0;
    while (!pix_ready_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, ".accept_bound"}, 32'(k < 20), 1);
    @(negedge clk);
    pix_valid_i = 1'b0;
    check({tag, ".stg_y"},  32'(stg_y_o),  32'(y));
    check({tag, ".stg_cb"}, 32'(stg_cb_o), 32'(cb));
    check({tag, ".stg_cr"}, 32'(stg_cr_o), 32'(cr));
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check({tag, ".stg_valid"}, 32'(stg_valid_o), 1);
      check({tag, ".stg_state"}, 32'(stg_state_o), 32'(i));
      check({tag, ".pix_ready_busy"}, 32'(pix_ready_o), 0);
    end
    for (int j = 0; j < n; j++) begin
      if (j > 0) @(negedge clk);
      res_valid_i = 1'b1;
      res_state_i = rt[j];
      res_data_i  = rd[j];
    end
    @(negedge clk);
    res_valid_i = 1'b0;
    check({tag, ".stg_idle"}, 32'(stg_valid_o), 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rgb_valid_o && k < 60);
    check({tag, ".out_latency"}, 32'(k), 32'(exp_wait));
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] hr, hg, hb;
    int b_exp;

    // Reset state
    #2 rst_n = 1'b0;
    #1 check_zero("reset_init");
    @(negedge clk);
    check_zero("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(pix_ready_o), 1);

    // 1: mid-grey, all rows return 128.0
    rt = '{2'd0, 2'd1, 2'd2, 2'd0};
    rd = '{ACC_W'('h08000), ACC_W'('h08000), ACC_W'('h08000), '0};
    run_pixel("t1", 8'd128, 8'd128, 8'd128, 3, 1);
    check_rgb("t1", 128, 128, 128, 0);
    @(negedge clk);
    check("t1.back_idle", 32'(rgb_valid_o), 0);

    // 2: clamp low, clamp high, half-LSB rounding boundary
`ifdef YCC2RGB_ROUND_EN
    b_exp = 128;
`else
    b_exp = 127;
`endif
    rd = '{ACC_W'(-5000), ACC_W'(70000), ACC_W'('h07F80), '0};
    run_pixel("t2", 8'd10, 8'd20, 8'd30, 3, 1);
    check_rgb("t2", 0, 255, b_exp, 0);
    @(negedge clk);

    // 3: out-of-order return 2,0,1
    rt = '{2'd2, 2'd0, 2'd1, 2'd0};
    rd = '{ACC_W'('h03200), ACC_W'('h06400), ACC_W'('h09600), '0};
    run_pixel("t3", 8'd200, 8'd50, 8'd90, 3, 1);
    check_rgb("t3", 100, 150, 50, 0);
    @(negedge clk);

    // 4: sink back-pressure for 10 cycles with a new pixel pending
    rt = '{2'd0, 2'd1, 2'd2, 2'd0};
    rd = '{ACC_W'('h00A00), ACC_W'('h01400), ACC_W'('h01E00), '0};
    rgb_ready_i = 1'b0;
    run_pixel("t4", 8'd1, 8'd2, 8'd3, 3, 1);
    check_rgb("t4", 10, 20, 30, 0);
    hr = r_o; hg = g_o; hb = b_o;
    y_i = 8'd77; cb_i = 8'd88; cr_i = 8'd99;
    pix_valid_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t4.hold_valid", 32'(rgb_valid_o), 1);
      check("t4.hold_r", 32'(r_o), 32'(hr));
      check("t4.hold_g", 32'(g_o), 32'(hg));
      check("t4.hold_b", 32'(b_o), 32'(hb));
      check("t4.hold_ready", 32'(pix_ready_o), 0);
      check("t4.hold_stg", 32'(stg_valid_o), 0);
    end
    check("t4.stg_y_kept", 32'(stg_y_o), 1);
    rgb_ready_i = 1'b1;
    pix_valid_i = 1'b0;
    @(negedge clk);
    check("t4.released_valid", 32'(rgb_valid_o), 0);
    check("t4.released_ready", 32'(pix_ready_o), 1);

    // 5: tag 1 missing -> timeout after TIMEOUT cycles in WAIT
    rt = '{2'd0, 2'd2, 2'd0, 2'd0};
    rd = '{ACC_W'('h02000), ACC_W'('h04000), '0, '0};
    run_pixel("t5", 8'd40, 8'd50, 8'd60, 2, 31);
    check_rgb("t5", 32, 0, 64, 1);
    @(negedge clk);
    rt = '{2'd0, 2'd1, 2'd2, 2'd0};
    rd = '{ACC_W'('h08000), ACC_W'('h08000), ACC_W'('h08000), '0};
    run_pixel("t5b", 8'd5, 8'd6, 8'd7, 3, 1);
    check_rgb("t5b", 128, 128, 128, 1);
    @(negedge clk);

    // 6: reset during WAIT, then a clean pixel
    y_i = 8'd11; cb_i = 8'd22; cr_i = 8'd33;
    pix_valid_i = 1'b1;
    @(negedge clk);
    pix_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    reset_pulse();
    rd = '{ACC_W'('h05000), ACC_W'('h0A000), ACC_W'('h0F000), '0};
    run_pixel("t6", 8'd12, 8'd34, 8'd56, 3, 1);
    check_rgb("t6", 80, 160, 240, 0);
    @(negedge clk);

    // Duplicate tag: second write overwrites and sets err
    rt = '{2'd0, 2'd0, 2'd1, 2'd2};
    rd = '{ACC_W'('h01000), ACC_W'('h02000), ACC_W'('h03000), ACC_W'('h04000)};
    run_pixel("dup", 8'd9, 8'd9, 8'd9, 4, 1);
    check_rgb("dup", 32, 48, 64, 1);
    @(negedge clk);
    reset_pulse();

    // Tag 3 ignored, sets err
    rt = '{2'd3, 2'd0, 2'd1, 2'd2};
    rd = '{ACC_W'('h0FF00), ACC_W'('h00500), ACC_W'('h00600), ACC_W'('h00700)};
    run_pixel("tag3", 8'd8, 8'd8, 8'd8, 4, 1);
    check_rgb("tag3", 5, 6, 7, 1);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
